// File: rtl/mips32_mem_reader_if.sv
// mips32_mem_reader_if
// Groups the request, memory-read and output-stream signals of the
// memory dump reader so they travel as one bundle.
//   start/base_addr/count : dump request (driven by the requester)
//   mem_rd_en/mem_addr    : read strobe and word address to the data memory
//   mem_rd_data           : registered memory data, valid the cycle after mem_rd_en
//   out_valid/out_ready   : output word handshake
//   out_data/out_addr     : dumped word and the address it came from
//   out_last              : final word of the dump
//   busy/done             : activity flag and completion pulse
// modport slave  : the reader itself
// modport master : the environment (requester, memory, downstream sink)
interface mips32_mem_reader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              busy;
    logic              done;

    modport slave (
        input  start, base_addr, count, mem_rd_data, out_ready,
        output mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last,
               busy, done
    );

    modport master (
        output start, base_addr, count, mem_rd_data, out_ready,
        input  mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last,
               busy, done
    );
endinterface

// File: rtl/mips32_mem_reader.sv
// mips32_mem_reader
// Dumps a contiguous block of data-memory words onto a valid/ready stream.
// A start pulse in IDLE latches the first word address and the word count;
// each word is read (one strobe), captured, then offered downstream until
// accepted. The address wraps modulo 2^ADDR_W, so a full-size count visits
// every address exactly once from any base.
//
// Ports:
//   clk1   : sole clock, rising edge
//   reset  : asynchronous, active-high; clears state and every output
//   bus    : mips32_mem_reader_if.slave (request, memory port, output stream)
//
// state | meaning
// IDLE  | waiting for start; outputs quiet, busy low
// REQ   | mem_rd_en high for one cycle at the current address
// CAP   | memory data arrives; capture word, address and last flag
// SEND  | out_valid high; word held stable until out_ready
// FIN   | done pulse, then back to IDLE
module mips32_mem_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk1,
    input  logic                  reset,
    mips32_mem_reader_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        CAP  = 3'd2,
        SEND = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W:0]   remaining;

    logic              mem_rd_en_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              out_last_r;
    logic              busy_r;
    logic              done_r;

    // All outputs are registered and follow the state they belong to:
    // each transition sets up the outputs of the state being entered.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            remaining   <= '0;
            mem_rd_en_r <= 1'b0;
            mem_addr_r  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_addr_r  <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if (bus.count != '0) begin
                            state       <= REQ;
                            addr_cnt    <= bus.base_addr;
                            remaining   <= bus.count;
                            mem_rd_en_r <= 1'b1;
                            mem_addr_r  <= bus.base_addr;
                        end else begin
                            // Empty dump: no read, no word, just completion.
                            state  <= FIN;
                            done_r <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    // mem_addr keeps its value; only the strobe drops.
                    mem_rd_en_r <= 1'b0;
                    state       <= CAP;
                end

                CAP: begin
                    out_data_r  <= bus.mem_rd_data;
                    out_addr_r  <= addr_cnt;
                    out_last_r  <= (remaining == REM_ONE);
                    out_valid_r <= 1'b1;
                    state       <= SEND;
                end

                SEND: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        remaining   <= remaining - 1'b1;
                        // Natural ADDR_W-bit overflow gives the wrap to 0.
                        addr_cnt    <= addr_cnt + 1'b1;
                        if (out_last_r) begin
                            state  <= FIN;
                            done_r <= 1'b1;
                        end else begin
                            state       <= REQ;
                            mem_rd_en_r <= 1'b1;
                            mem_addr_r  <= addr_cnt + 1'b1;
                        end
                    end
                end

                FIN: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state       <= IDLE;
                    mem_rd_en_r <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = mem_rd_en_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_addr  = out_addr_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_mips32_mem_reader.sv
// tb_mips32_mem_reader
// Scoreboard bench: each accepted start pushes the expected read addresses and
// output words (taken from the bench's own memory image) into queues; a
// negedge monitor pops and compares as the reader strobes memory and emits
// words, and also checks hold-while-stalled and done timing.
module tb_mips32_mem_reader;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic clk1  = 1'b0;
    logic reset = 1'b0;
    always #5 clk1 = ~clk1;

    mips32_mem_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mips32_mem_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk1  (clk1),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Memory model: registered read, data valid the cycle after the strobe.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk1) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          last;
    } word_t;

    word_t         exp_q[$];
    logic [AW-1:0] rd_q[$];
    int checks = 0, errors = 0;
    int done_seen = 0, done_exp = 0, rd_seen = 0;
    bit expect_done_next = 0;
    bit ready_auto = 1, ready_rand = 0, ready_manual = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: a dump of cnt words from base reads (base+i) mod DEPTH.
    function automatic void push_dump(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int a;
            word_t w;
            a = (base + i) % DEPTH;
            w.a = AW'(a);
            w.d = mem[a];
            w.last = (i == cnt - 1);
            exp_q.push_back(w);
            rd_q.push_back(AW'(a));
        end
        done_exp++;
    endfunction

    // Ready driver: the only writer of out_ready.
    always @(posedge clk1) begin
        #1;
        if (ready_auto) bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        else            bus.out_ready = ready_manual;
    end

    // Monitor
    word_t         mon_w, mon_prev;
    logic [AW-1:0] mon_ra;
    bit            prev_hold = 0;
    always @(negedge clk1) begin
        if (reset) begin
            prev_hold = 0;
            expect_done_next = 0;
        end else begin
            if (expect_done_next) begin
                chk("done_after_last", bus.done, 1);
                expect_done_next = 0;
            end
            if (bus.done) done_seen++;
            if (bus.mem_rd_en) begin
                rd_seen++;
                chk("rd_while_valid", bus.out_valid, 0);
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %0d, expected no read", bus.mem_addr);
                end else begin
                    mon_ra = rd_q.pop_front();
                    chk("mem_addr", bus.mem_addr, mon_ra);
                end
            end
            if (prev_hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, mon_prev.d);
                chk("hold_addr", bus.out_addr, mon_prev.a);
                chk("hold_last", bus.out_last, mon_prev.last);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got addr %0d data %0d, expected none",
                             bus.out_addr, bus.out_data);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("out_addr", bus.out_addr, mon_w.a);
                    chk("out_data", bus.out_data, mon_w.d);
                    chk("out_last", bus.out_last, mon_w.last);
                    if (mon_w.last) expect_done_next = 1;
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            mon_prev.a = bus.out_addr;
            mon_prev.d = bus.out_data;
            mon_prev.last = bus.out_last;
        end
    end

    task automatic start_dump(input int base, input int cnt, input bit push);
        @(posedge clk1); #1;
        bus.start = 1'b1;
        bus.base_addr = AW'(base);
        bus.count = (AW + 1)'(cnt);
        if (push) push_dump(base, cnt);
        @(posedge clk1); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk1);
            n++;
        end while ((bus.busy || exp_q.size() != 0) && n < 20000);
        chk({name, "_timeout"}, (n >= 20000) ? 1 : 0, 0);
        @(negedge clk1);
        chk({name, "_done_count"}, done_seen, done_exp);
        chk({name, "_reads_left"}, rd_q.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_mem_rd_en"}, bus.mem_rd_en, 0);
        chk({name, "_mem_addr"},  bus.mem_addr, 0);
        chk({name, "_out_valid"}, bus.out_valid, 0);
        chk({name, "_out_data"},  bus.out_data, 0);
        chk({name, "_out_addr"},  bus.out_addr, 0);
        chk({name, "_out_last"},  bus.out_last, 0);
        chk({name, "_busy"},      bus.busy, 0);
        chk({name, "_done"},      bus.done, 0);
    endtask

    initial begin
        int r0, n;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[198] = 32'd5040;
        mem[199] = 32'd0;
        mem[200] = 32'd7;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.count = '0;

        // Asynchronous reset, checked between clock edges.
        #2 reset = 1'b1;
        #1 chk_outputs_zero("reset");
        repeat (2) @(negedge clk1);
        reset = 1'b0;

        // Three-word dump with known data.
        start_dump(198, 3, 1);
        wait_idle("t_basic");

        // Address wrap from the top of memory.
        start_dump(1023, 2, 1);
        wait_idle("t_wrap");

        // Empty dump: done on the next cycle, no reads, no words.
        r0 = rd_seen;
        start_dump(5, 0, 1);
        @(negedge clk1);
        chk("t_zero_done", bus.done, 1);
        chk("t_zero_busy", bus.busy, 1);
        @(negedge clk1);
        chk("t_zero_done_low", bus.done, 0);
        wait_idle("t_zero");
        chk("t_zero_no_reads", rd_seen, r0);

        // Back-pressure: word stays put, no new read until accepted.
        ready_auto = 0;
        ready_manual = 0;
        start_dump(100, 2, 1);
        n = 0;
        do begin
            @(negedge clk1);
            n++;
        end while (!bus.out_valid && n < 50);
        chk("t_stall_valid_seen", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t_stall_valid", bus.out_valid, 1);
            chk("t_stall_no_rd", bus.mem_rd_en, 0);
            @(negedge clk1);
        end
        ready_auto = 1;
        ready_rand = 0;
        wait_idle("t_stall");

        // start while busy is ignored.
        start_dump(10, 4, 1);
        repeat (4) @(posedge clk1);
        start_dump(0, 4, 0);
        wait_idle("t_restart");

        // Random dumps under random back-pressure.
        ready_rand = 1;
        for (int k = 0; k < 12; k++) begin
            start_dump($urandom_range(0, DEPTH - 1), $urandom_range(0, 6), 1);
            wait_idle("t_rand");
        end

        // Full-memory dump from a nonzero base.
        ready_rand = 0;
        start_dump($urandom_range(1, DEPTH - 1), DEPTH, 1);
        wait_idle("t_full");

        // Reset in CAP of the second word abandons the dump.
        r0 = rd_seen;
        start_dump(10, 3, 1);
        n = 0;
        while (rd_seen < r0 + 2 && n < 100) begin
            @(negedge clk1);
            n++;
        end
        chk("t_rst_reach_cap", rd_seen, r0 + 2);
        @(posedge clk1);
        #2 reset = 1'b1;
        #1 chk_outputs_zero("t_rst_mid");
        exp_q.delete();
        rd_q.delete();
        done_seen = 0;
        done_exp = 0;
        repeat (2) @(negedge clk1);
        reset = 1'b0;
        repeat (5) @(negedge clk1);
        chk("t_rst_no_done", done_seen, 0);
        chk("t_rst_idle", bus.busy, 0);
        start_dump(5, 1, 1);
        wait_idle("t_rst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips32_mem_reader.md
MIPS32_MEM_READER -- requirements
Module: mips32_mem_reader

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the data memory port.
REQ-002 Parameter DATA_W, default 32, memory and output word width.
REQ-003 Port clk1  input  1  sole clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 Port base_addr  input  ADDR_W  first word address, sampled with start.
REQ-007 Port count  input  ADDR_W+1  number of words to dump (0..2^ADDR_W), sampled with start.
REQ-008 Port mem_rd_en  output  1  memory read strobe.
REQ-009 Port mem_addr  output  ADDR_W  memory word address.
REQ-010 Port mem_rd_data  input  DATA_W  registered read data, valid the cycle after mem_rd_en.
REQ-011 Port out_valid  output  1  out_data/out_addr/out_last hold a word.
REQ-012 Port out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-013 Port out_data  output  DATA_W  dumped word.
REQ-014 Port out_addr  output  ADDR_W  address the word was read from.
REQ-015 Port out_last  output  1  marks the final word of the dump.
REQ-016 Port busy  output  1  high in every state except IDLE.
REQ-017 Port done  output  1  one-cycle pulse at dump completion.

Function
REQ-018 FSM states SHALL be IDLE, REQ, CAP, SEND, FIN.
REQ-019 IDLE: start=1 with count>0 -> REQ; latch base_addr into address counter, count into remaining counter.
REQ-020 IDLE: start=1 with count=0 -> FIN; no memory read issued, no word output.
REQ-021 REQ: mem_rd_en=1, mem_addr=address counter, for exactly one cycle; -> CAP.
REQ-022 CAP: mem_rd_data captured into out_data, address counter into out_addr, out_last=(remaining==1); -> SEND.
REQ-023 SEND: out_valid=1; out_data, out_addr, out_last SHALL stay stable while out_ready=0.
REQ-024 SEND with out_ready=1: word accepted; remaining decrements; address counter increments modulo 2^ADDR_W (wrap 1023 -> 0); -> FIN if out_last else REQ.
REQ-025 FIN: done=1 for one cycle; -> IDLE.
REQ-026 Minimum throughput SHALL be one word per 3 cycles (REQ, CAP, SEND with out_ready held high).
REQ-027 start asserted while busy SHALL be ignored; in-progress dump parameters unchanged.
REQ-028 mem_rd_en SHALL be 0 in all states other than REQ; mem_addr SHALL hold its last value otherwise.
REQ-029 out_valid SHALL be 0 in all states other than SEND.
REQ-030 count=2^ADDR_W SHALL dump every address exactly once, wrapping if base_addr>0.

Reset
REQ-031 reset=1 SHALL immediately, without a clock edge, force state IDLE and all outputs to 0 (mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy, done).
REQ-032 Reset mid-dump SHALL abandon the transfer; no done pulse; first start after release begins a fresh dump.

Verification
REQ-033 Mem[198]=5040, Mem[199]=0, Mem[200]=7; start, base=198, count=3, out_ready=1 -> words (198,5040), (199,0), (200,7); out_last only on third; done pulse 1 cycle after third acceptance.
REQ-034 base=1023, count=2 -> mem_addr sequence 1023 then 0; out_addr 1023, 0.
REQ-035 count=0 start -> done pulse next cycle; mem_rd_en never asserted; out_valid never asserted.
REQ-036 out_ready held low 5 cycles in SEND -> out_valid high all 5 cycles, out_data/out_addr unchanged, no new mem_rd_en until acceptance.
REQ-037 start re-pulsed with base=0 during dump of base=10, count=4 -> output addresses 10..13 only; single done.
REQ-038 reset asserted in CAP of second word -> all outputs 0 asynchronously; no done; subsequent start base=5, count=1 -> single word from address 5 with out_last=1.
